pe_array_feeder: RTL and testbench

- Drive-side sequencer for the 64-input bit-fusion PE array.
- Accepts one dot-product job: length in beats, precision code and bias.
- Streams activation/weight beats into the array's i_Act/i_Weight/i_Sel_Bias/core_vld/i_Flush interface.
- Waits out the array's fixed result latency, captures o_Psum and presents it on a valid/ready result port.

---
 rtl/pe_array_feeder.sv | 168 ++++++++++++++++
 tb/tb_pe_array_feeder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_feeder.sv
// Drive-side sequencer for the bit-fusion PE array. It takes one dot-product job,
// streams its beats into the array, waits out the result latency and holds the result.
module pe_array_feeder #(
  parameter int ACT_W   = 128,
  parameter int WGT_W   = 128,
  parameter int BIAS_W  = 16,
  parameter int PSUM_W  = 32,
  parameter int LEN_W   = 16,
  parameter int RES_LAT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_Start,
  input  logic [LEN_W-1:0]  i_Len,
  input  logic [3:0]        i_Precision,
  input  logic [BIAS_W-1:0] i_Bias,
  output logic              o_Busy,
  input  logic              i_Vld,
  output logic              o_Rdy,
  input  logic [ACT_W-1:0]  i_Act_Data,
  input  logic [WGT_W-1:0]  i_Wgt_Data,
  output logic [ACT_W-1:0]  o_Act,
  output logic [WGT_W-1:0]  o_Weight,
  output logic [3:0]        o_Precision,
  output logic [BIAS_W-1:0] o_Bias,
  output logic              o_Sel_Bias,
  output logic              o_Flush,
  output logic              o_Core_Vld,
  input  logic [PSUM_W-1:0] i_Psum,
  output logic              o_Res_Vld,
  input  logic              i_Res_Rdy,
  output logic [PSUM_W-1:0] o_Res
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, HOLD} state_t;

  localparam logic [3:0] RES_LAT_C = 4'(RES_LAT);

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   rem, rem_nxt;
  logic [3:0]         drain_cnt, drain_nxt;
  logic               first, first_nxt;

  logic               busy_nxt, rdy_nxt, sel_bias_nxt, flush_nxt, core_vld_nxt, res_vld_nxt;
  logic [ACT_W-1:0]   act_nxt;
  logic [WGT_W-1:0]   weight_nxt;
  logic [3:0]         precision_nxt;
  logic [BIAS_W-1:0]  bias_nxt;
  logic [PSUM_W-1:0]  res_nxt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      rem         <= '0;
      drain_cnt   <= '0;
      first       <= 1'b0;
      o_Busy      <= 1'b0;
      o_Rdy       <= 1'b0;
      o_Act       <= '0;
      o_Weight    <= '0;
      o_Precision <= '0;
      o_Bias      <= '0;
      o_Sel_Bias  <= 1'b0;
      o_Flush     <= 1'b0;
      o_Core_Vld  <= 1'b0;
      o_Res_Vld   <= 1'b0;
      o_Res       <= '0;
    end else begin
      state       <= state_nxt;
      rem         <= rem_nxt;
      drain_cnt   <= drain_nxt;
      first       <= first_nxt;
      o_Busy      <= busy_nxt;
      o_Rdy       <= rdy_nxt;
      o_Act       <= act_nxt;
      o_Weight    <= weight_nxt;
      o_Precision <= precision_nxt;
      o_Bias      <= bias_nxt;
      o_Sel_Bias  <= sel_bias_nxt;
      o_Flush     <= flush_nxt;
      o_Core_Vld  <= core_vld_nxt;
      o_Res_Vld   <= res_vld_nxt;
      o_Res       <= res_nxt;
    end
  end

  // Every output is registered, so this block computes the value each one takes at the next edge.
  always_comb begin
    state_nxt     = state;
    rem_nxt       = rem;
    drain_nxt     = drain_cnt;
    first_nxt     = first;
    busy_nxt      = o_Busy;
    rdy_nxt       = o_Rdy;
    act_nxt       = o_Act;
    weight_nxt    = o_Weight;
    precision_nxt = o_Precision;
    bias_nxt      = o_Bias;
    sel_bias_nxt  = o_Sel_Bias;
    flush_nxt     = 1'b0;
    core_vld_nxt  = o_Core_Vld;
    res_vld_nxt   = o_Res_Vld;
    res_nxt       = o_Res;

    case (state)
      IDLE: begin
        if (i_Start) begin
          busy_nxt = 1'b1;
          if (i_Len != '0) begin
            rem_nxt       = i_Len;
            precision_nxt = i_Precision;
            bias_nxt      = i_Bias;
            first_nxt     = 1'b1;
            rdy_nxt       = 1'b1;
            state_nxt     = FEED;
          end else begin
            // An empty job reduces to its bias; the array is never touched.
            res_nxt     = PSUM_W'(signed'(i_Bias));
            res_vld_nxt = 1'b1;
            state_nxt   = HOLD;
          end
        end
      end

      FEED: begin
        if (i_Vld && o_Rdy) begin
          act_nxt      = i_Act_Data;
          weight_nxt   = i_Wgt_Data;
          core_vld_nxt = 1'b1;
          sel_bias_nxt = first;
          first_nxt    = 1'b0;
          rem_nxt      = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            rdy_nxt   = 1'b0;
            drain_nxt = RES_LAT_C;
            state_nxt = DRAIN;
          end
        end else begin
          core_vld_nxt = 1'b0;
          sel_bias_nxt = 1'b0;
        end
      end

      DRAIN: begin
        core_vld_nxt = 1'b0;
        sel_bias_nxt = 1'b0;
        drain_nxt    = drain_cnt - 4'd1;
        if (drain_cnt == 4'd1) begin
          res_nxt     = i_Psum;
          res_vld_nxt = 1'b1;
          flush_nxt   = 1'b1;
          state_nxt   = HOLD;
        end
      end

      HOLD: begin
        if (o_Res_Vld && i_Res_Rdy) begin
          res_vld_nxt = 1'b0;
          busy_nxt    = 1'b0;
          state_nxt   = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Directed bench for pe_array_feeder with a small behavioural PE array model
// (sum of 16-bit act*wgt products plus bias, result visible RES_LAT edges after the last beat).
module tb_pe_array_feeder;

  localparam int ACT_W   = 128;
  localparam int WGT_W   = 128;
  localparam int BIAS_W  = 16;
  localparam int PSUM_W  = 32;
  localparam int LEN_W   = 16;
  localparam int RES_LAT = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic              i_Start;
  logic [LEN_W-1:0]  i_Len;
  logic [3:0]        i_Precision;
  logic [BIAS_W-1:0] i_Bias;
  logic              o_Busy;
  logic              i_Vld;
  logic              o_Rdy;
  logic [ACT_W-1:0]  i_Act_Data;
  logic [WGT_W-1:0]  i_Wgt_Data;
  logic [ACT_W-1:0]  o_Act;
  logic [WGT_W-1:0]  o_Weight;
  logic [3:0]        o_Precision;
  logic [BIAS_W-1:0] o_Bias;
  logic              o_Sel_Bias;
  logic              o_Flush;
  logic              o_Core_Vld;
  logic [PSUM_W-1:0] i_Psum;
  logic              o_Res_Vld;
  logic              i_Res_Rdy;
  logic [PSUM_W-1:0] o_Res;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 CLK = ~CLK;

  pe_array_feeder #(
    .ACT_W(ACT_W), .WGT_W(WGT_W), .BIAS_W(BIAS_W),
    .PSUM_W(PSUM_W), .LEN_W(LEN_W), .RES_LAT(RES_LAT)
  ) dut (
    .CLK(CLK), .RST(RST),
    .i_Start(i_Start), .i_Len(i_Len), .i_Precision(i_Precision), .i_Bias(i_Bias),
    .o_Busy(o_Busy), .i_Vld(i_Vld), .o_Rdy(o_Rdy),
    .i_Act_Data(i_Act_Data), .i_Wgt_Data(i_Wgt_Data),
    .o_Act(o_Act), .o_Weight(o_Weight), .o_Precision(o_Precision), .o_Bias(o_Bias),
    .o_Sel_Bias(o_Sel_Bias), .o_Flush(o_Flush), .o_Core_Vld(o_Core_Vld),
    .i_Psum(i_Psum), .o_Res_Vld(o_Res_Vld), .i_Res_Rdy(i_Res_Rdy), .o_Res(o_Res)
  );

  // The array accumulates one edge after core_vld launches, then two pipeline stages give RES_LAT=4.
  logic [31:0] acc   = '0;
  logic [31:0] pipe1 = '0;
  logic [31:0] pipe2 = '0;

  always @(posedge CLK) begin
    if (o_Core_Vld)
      acc <= (o_Sel_Bias ? {{16{o_Bias[15]}}, o_Bias} : acc)
             + 32'(o_Act[15:0]) * 32'(o_Weight[15:0]);
    pipe1 <= acc;
    pipe2 <= pipe1;
  end

  assign i_Psum = pipe2;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [15:0] len, input logic [3:0] prec,
                               input logic [15:0] bias, input logic vld, input logic [127:0] act,
                               input logic [127:0] wgt, input logic res_rdy);
    i_Start     = start;
    i_Len       = len;
    i_Precision = prec;
    i_Bias      = bias;
    i_Vld       = vld;
    i_Act_Data  = act;
    i_Wgt_Data  = wgt;
    i_Res_Rdy   = res_rdy;
    @(posedge CLK);
    #1;
  endtask

  task automatic idleCycle(input logic res_rdy);
    applyStimulus(1'b0, 16'd0, 4'd0, 16'd0, 1'b0, 128'd0, 128'd0, res_rdy);
  endtask

  bit vld_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int exp_act [7] = '{1, 1, 1, 2, 3, 3, 4};

  initial begin
    int k;
    RST = 1'b0;
    i_Start = 1'b0; i_Len = '0; i_Precision = '0; i_Bias = '0;
    i_Vld = 1'b0; i_Act_Data = '0; i_Wgt_Data = '0; i_Res_Rdy = 1'b0;

    @(posedge CLK);
    #1;
    checkOutput("reset_busy", 128'(o_Busy), 128'd0);
    checkOutput("reset_rdy", 128'(o_Rdy), 128'd0);
    checkOutput("reset_res_vld", 128'(o_Res_Vld), 128'd0);
    checkOutput("reset_res", 128'(o_Res), 128'd0);
    checkOutput("reset_core_vld", 128'(o_Core_Vld), 128'd0);
    checkOutput("reset_act", o_Act, 128'd0);
    RST = 1'b1;
    idleCycle(1'b0);

    $display("[TB] job 1: len 3, bias 5, precision 1010");
    applyStimulus(1'b1, 16'd3, 4'b1010, 16'd5, 1'b0, 128'd0, 128'd0, 1'b0);
    checkOutput("j1_busy", 128'(o_Busy), 128'd1);
    checkOutput("j1_rdy", 128'(o_Rdy), 128'd1);
    checkOutput("j1_prec", 128'(o_Precision), 128'hA);
    checkOutput("j1_bias", 128'(o_Bias), 128'd5);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 16'd0, 4'd0, 16'd0, 1'b1, 128'(i + 2), 128'(i + 5), 1'b0);
      checkOutput("j1_core_vld", 128'(o_Core_Vld), 128'd1);
      checkOutput("j1_sel_bias", 128'(o_Sel_Bias), 128'(i == 0));
      checkOutput("j1_act", o_Act, 128'(i + 2));
      checkOutput("j1_rdy_feed", 128'(o_Rdy), 128'(i < 2));
    end
    for (int i = 0; i < RES_LAT; i++) begin
      idleCycle(1'b0);
      checkOutput("j1_drain_res_vld", 128'(o_Res_Vld), 128'(i == RES_LAT - 1));
      checkOutput("j1_drain_flush", 128'(o_Flush), 128'(i == RES_LAT - 1));
      checkOutput("j1_drain_core_vld", 128'(o_Core_Vld), 128'd0);
      checkOutput("j1_drain_prec", 128'(o_Precision), 128'hA);
    end
    checkOutput("j1_res", 128'(o_Res), 128'd61);
    idleCycle(1'b0);
    checkOutput("j1_flush_drop", 128'(o_Flush), 128'd0);
    checkOutput("j1_hold_vld", 128'(o_Res_Vld), 128'd1);
    checkOutput("j1_hold_res", 128'(o_Res), 128'd61);
    idleCycle(1'b1);
    checkOutput("j1_pop_vld", 128'(o_Res_Vld), 128'd0);
    checkOutput("j1_pop_busy", 128'(o_Busy), 128'd0);
    checkOutput("j1_idle_prec", 128'(o_Precision), 128'hA);

    $display("[TB] job 2: len 4 with gapped valid, precision 0000");
    applyStimulus(1'b1, 16'd4, 4'b0000, 16'd0, 1'b0, 128'd0, 128'd0, 1'b0);
    checkOutput("j2_prec", 128'(o_Precision), 128'd0);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 16'd0, 4'd0, 16'd0, vld_pat[i],
                    vld_pat[i] ? 128'(k + 1) : 128'hDEAD, 128'd1, 1'b0);
      if (vld_pat[i]) k++;
      checkOutput("j2_core_vld", 128'(o_Core_Vld), 128'(vld_pat[i]));
      checkOutput("j2_act", o_Act, 128'(exp_act[i]));
      checkOutput("j2_rdy", 128'(o_Rdy), 128'(i < 6));
      checkOutput("j2_sel_bias", 128'(o_Sel_Bias), 128'(i == 0));
    end
    for (int i = 0; i < RES_LAT; i++) begin
      idleCycle(1'b1);
      checkOutput("j2_drain_res_vld", 128'(o_Res_Vld), 128'(i == RES_LAT - 1));
    end
    checkOutput("j2_res", 128'(o_Res), 128'd10);
    idleCycle(1'b1);
    checkOutput("j2_pop_vld", 128'(o_Res_Vld), 128'd0);
    checkOutput("j2_pop_busy", 128'(o_Busy), 128'd0);

    $display("[TB] job 3: len 0, bias -3, long hold with ignored start");
    applyStimulus(1'b1, 16'd0, 4'd0, 16'hFFFD, 1'b0, 128'd0, 128'd0, 1'b0);
    checkOutput("j3_res_vld", 128'(o_Res_Vld), 128'd1);
    checkOutput("j3_res", 128'(o_Res), 128'hFFFF_FFFD);
    checkOutput("j3_core_vld", 128'(o_Core_Vld), 128'd0);
    checkOutput("j3_busy", 128'(o_Busy), 128'd1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'(i == 4), 16'd5, 4'd3, 16'd1, 1'b0, 128'd0, 128'd0, 1'b0);
      checkOutput("j3_hold_res", 128'(o_Res), 128'hFFFF_FFFD);
      checkOutput("j3_hold_vld", 128'(o_Res_Vld), 128'd1);
      checkOutput("j3_hold_busy", 128'(o_Busy), 128'd1);
      checkOutput("j3_hold_rdy", 128'(o_Rdy), 128'd0);
    end
    applyStimulus(1'b1, 16'd2, 4'd3, 16'd1, 1'b0, 128'd0, 128'd0, 1'b1);
    checkOutput("j3_pop_vld", 128'(o_Res_Vld), 128'd0);
    checkOutput("j3_pop_busy", 128'(o_Busy), 128'd0);
    idleCycle(1'b0);
    checkOutput("j3_start_dropped", 128'(o_Busy), 128'd0);
    checkOutput("j3_prec_unchanged", 128'(o_Precision), 128'd0);

    $display("[TB] job 4: reset after 2 of 5 beats, then len 1");
    applyStimulus(1'b1, 16'd5, 4'h5, 16'd9, 1'b0, 128'd0, 128'd0, 1'b0);
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b0, 16'd0, 4'd0, 16'd0, 1'b1, 128'd8, 128'd8, 1'b0);
    checkOutput("j4_pre_reset_core", 128'(o_Core_Vld), 128'd1);
    #2 RST = 1'b0;
    #1;
    checkOutput("j4_rst_act", o_Act, 128'd0);
    checkOutput("j4_rst_wgt", o_Weight, 128'd0);
    checkOutput("j4_rst_rdy", 128'(o_Rdy), 128'd0);
    checkOutput("j4_rst_busy", 128'(o_Busy), 128'd0);
    checkOutput("j4_rst_core", 128'(o_Core_Vld), 128'd0);
    checkOutput("j4_rst_prec", 128'(o_Precision), 128'd0);
    checkOutput("j4_rst_bias", 128'(o_Bias), 128'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 16'd0, 4'd0, 16'd0, 1'b1, 128'd8, 128'd8, 1'b1);
      checkOutput("j4_after_rst_res_vld", 128'(o_Res_Vld), 128'd0);
      checkOutput("j4_after_rst_core", 128'(o_Core_Vld), 128'd0);
    end
    applyStimulus(1'b1, 16'd1, 4'd0, 16'd2, 1'b0, 128'd0, 128'd0, 1'b0);
    checkOutput("j4b_rdy", 128'(o_Rdy), 128'd1);
    checkOutput("j4b_bias", 128'(o_Bias), 128'd2);
    applyStimulus(1'b0, 16'd0, 4'd0, 16'd0, 1'b1, 128'd7, 128'd3, 1'b0);
    checkOutput("j4b_core", 128'(o_Core_Vld), 128'd1);
    checkOutput("j4b_sel", 128'(o_Sel_Bias), 128'd1);
    checkOutput("j4b_rdy_drop", 128'(o_Rdy), 128'd0);
    for (int i = 0; i < RES_LAT; i++) begin
      idleCycle(1'b0);
      checkOutput("j4b_drain_res_vld", 128'(o_Res_Vld), 128'(i == RES_LAT - 1));
    end
    checkOutput("j4b_res", 128'(o_Res), 128'd23);
    idleCycle(1'b1);
    checkOutput("j4b_pop_busy", 128'(o_Busy), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
